// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the instruction/data memory bus arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } arbState_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   // Cycles a single bus phase may last before the watchdog aborts it.
   localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_wdog.sv
// Bus phase watchdog: counts cycles spent in one address/data phase and flags
// expiry on the cycle that completes TIMEOUT cycles in that phase. Only built
// into the arbiter when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_wdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,  // phase is changing this cycle
   input  logic run,      // a bus phase is in progress
   output logic expired
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] phaseCnt;

   assign expired = run && (phaseCnt == CNT_W'(TIMEOUT - 1));

   // Phase cycle counter, cleared whenever the arbiter changes state.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!reset) begin
         phaseCnt <= '0;
      end else if (restart) begin
         phaseCnt <= '0;
      end else if (run && !expired) begin
         phaseCnt <= phaseCnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter for the 5-stage pipeline: serialises fetch and load/store
// requests onto one SRAM-like bus, data before fetch, and returns 1-cycle
// completion pulses. A pending fetch can be discarded by inst_flush.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (per-phase watchdog + bus_err).
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_flush,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_ok,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [3:0]        data_wea,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_ok,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [3:0]        bus_wea,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_data_ok,
   output logic              bus_err
);

   if (TIMEOUT < 1) begin : gBadTimeout
      $error("mem_bus_arbiter: TIMEOUT must be at least 1");
   end

   arbState_e         state, stateNext;
   owner_e            owner;
   logic              discard;
   logic              timeoutHit;
   logic              timeoutTaken;
   logic              respLoad;
   logic              flushOwn;
   logic [DATA_W-1:0] respData;

   logic [ADDR_W-1:0] addrQ;
   logic              wrQ;
   logic [3:0]        weaQ;
   logic [DATA_W-1:0] wdataQ;
   logic [DATA_W-1:0] instRdataQ;
   logic [DATA_W-1:0] dataRdataQ;

   // Next-state decode; a watchdog expiry only wins when the slave is silent.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      stateNext    = state;
      timeoutTaken = 1'b0;
      unique case (state)
         IDLE: begin
            if (data_req || inst_req) stateNext = ADDR;
         end
         ADDR: begin
            if (bus_addr_ok) begin
               stateNext = DATA;
            end else if (timeoutHit) begin
               stateNext    = RESP;
               timeoutTaken = 1'b1;
            end
         end
         DATA: begin
            if (bus_data_ok) begin
               stateNext = RESP;
            end else if (timeoutHit) begin
               stateNext    = RESP;
               timeoutTaken = 1'b1;
            end
         end
         RESP: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign respLoad = ((state == ADDR) || (state == DATA)) && (stateNext == RESP);
   assign respData = timeoutTaken ? '0 : bus_rdata;
   assign flushOwn = inst_flush && (owner == OWN_INST) && (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= stateNext;
   end

   // Latch the winning request's fields when leaving IDLE.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: datapath registers are reset too, so every output reads 0 in reset.
      if (!reset) begin
         owner  <= OWN_INST;
         addrQ  <= '0;
         wrQ    <= 1'b0;
         weaQ   <= 4'b0000;
         wdataQ <= '0;
      end else if ((state == IDLE) && (data_req || inst_req)) begin
         owner  <= data_req ? OWN_DATA : OWN_INST;
         addrQ  <= data_req ? data_addr : inst_addr;
         wrQ    <= data_req && data_wr;
         weaQ   <= (data_req && data_wr) ? data_wea : 4'b0000;
         wdataQ <= data_req ? data_wdata : '0;
      end
   end

   // Discard flag: set by a flush of an owned fetch, cleared on return to IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         discard <= 1'b0;
      end else if (stateNext == IDLE) begin
         discard <= 1'b0;
      end else if (flushOwn) begin
         discard <= 1'b1;
      end
   end

   // Capture the response into the owner's read-data register on RESP entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instRdataQ <= '0;
         dataRdataQ <= '0;
      end else if (respLoad) begin
         if (owner == OWN_DATA) begin
            dataRdataQ <= respData;
         end else if (!discard && !flushOwn) begin
            instRdataQ <= respData;
         end
      end
   end

   assign bus_req    = (state == ADDR);
   assign bus_wr     = wrQ;
   assign bus_wea    = wrQ ? weaQ : 4'b0000;
   assign bus_addr   = addrQ;
   assign bus_wdata  = wdataQ;

   assign inst_ok    = (state == RESP) && (owner == OWN_INST) && !discard && !inst_flush;
   assign data_ok    = (state == RESP) && (owner == OWN_DATA);
   assign inst_rdata = instRdataQ;
   assign data_rdata = dataRdataQ;

`ifdef MEM_ARB_TIMEOUT_EN
   logic busErrQ;

   mem_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) uWdog (
      .clk     (clk),
      .reset   (reset),
      .restart (stateNext != state),
      .run     ((state == ADDR) || (state == DATA)),
      .expired (timeoutHit)
   );

   // Sticky error flag: any aborted phase sets it until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            busErrQ <= 1'b0;
      else if (timeoutTaken) busErrQ <= 1'b1;
   end

   assign bus_err = busErrQ;
`else
   assign timeoutHit = 1'b0;
   assign bus_err    = 1'b0;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between instruction fetch and data memory (load/store) requesters of the 5-stage pipeline.
- Serialises transactions, with data priority over fetch.
- Returns per-requester 1-cycle completion pulses used by the hazard unit for stall release.
- Supports discarding an in-flight fetch on exception/branch flush.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- TIMEOUT, 255, cycles allowed per bus phase before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held with inst_addr until inst_ok
- inst_addr  in  ADDR_W  fetch address
- inst_flush  in  1  1-cycle pulse; discard the outstanding fetch response
- inst_rdata  out  DATA_W  fetch data, valid with inst_ok
- inst_ok  out  1  1-cycle fetch completion pulse
- data_req  in  1  data request; held with its fields until data_ok
- data_wr  in  1  1 = store, 0 = load
- data_wea  in  4  byte enables for stores
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data, valid with data_ok
- data_ok  out  1  1-cycle data completion pulse
- bus_req  out  1  bus address-phase request
- bus_wr  out  1  bus write flag
- bus_wea  out  4  bus byte enables (0 for reads)
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_addr_ok  in  1  slave accepted the address phase
- bus_rdata  in  DATA_W  slave read data
- bus_data_ok  in  1  slave data phase complete
- bus_err  out  1  sticky timeout error flag (0 without the macro)

Behaviour:
- Reset (reset=0, async):
  - State returns to IDLE; owner and discard are cleared.
  - All outputs go to 0. Any in-flight transaction is abandoned without an ok pulse.
- State machine:
  - IDLE -> ADDR: when data_req or inst_req is 1. data_req wins when both are set. The owner, addr, wr, wea and wdata are latched.
  - ADDR: bus_req=1 and all bus_* fields come from registers. bus_addr_ok=1 clears bus_req next cycle and moves to DATA.
  - DATA: bus_req=0. bus_data_ok=1 moves to RESP, latching bus_rdata into the owner's rdata register.
  - RESP: the owner's ok pulses for exactly 1 cycle, then the state returns to IDLE. No arbitration happens in RESP.
- Latency: request seen at cycle N gives bus_req at N+1. With zero-wait slave (addr_ok at N+1, data_ok at N+2), ok pulses at N+3. Minimum spacing between bus_req assertions is 4 cycles.
- bus_data_ok is ignored outside DATA. bus_addr_ok is ignored outside ADDR.
- Writes: data_rdata is driven with whatever the bus returned. data_ok pulses the same way as for reads.
- bus_wea forced to 0 when bus_wr=0. For fetch transactions, bus_wr=0 and bus_wea=0.
- inst_rdata/data_rdata hold their value until the next completion of the same requester.
- Flush:
  - inst_flush while owner=inst in ADDR, DATA or RESP sets discard. The bus transaction still completes, inst_ok is suppressed and inst_rdata is not updated.
  - In RESP, flush and ok in the same cycle: ok is suppressed.
  - discard clears on return to IDLE.
  - inst_flush in IDLE, or while owner=data, has no effect.
- Requester dropping req before ok is a protocol violation. The transaction still completes and ok still pulses.
- No starvation guarantee for fetch: the pipeline stalls fetch while data is pending.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A phase counter runs in ADDR and DATA and resets on each state entry.
  - Reaching TIMEOUT cycles forces RESP with the owner's rdata set to 0 and sets bus_err=1.
  - bus_err stays set until reset.
  - ok still pulses unless discarded.
- Undefined: no counter exists, bus_err is tied to 0, and the block waits indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2, RESP=2'd3)
  - owner encoding (OWN_INST=1'b0, OWN_DATA=1'b1)
  - default TIMEOUT constant
- Sub-module mem_arb_wdog: the timeout counter. Instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Single fetch, zero-wait slave: inst_req=1, inst_addr=0xBFC00000 at cycle 0; addr_ok at 1, data_ok at 2 with rdata=0x24010001 -> bus_req high only cycle 1, inst_ok at cycle 3, inst_rdata=0x24010001.
- Simultaneous requests: inst_req and data_req (store, addr 0x80000010, wea=4'b0011, wdata=0x0000BEEF) in the same cycle -> the first bus_req is the store with bus_wea=0011. The fetch follows after data_ok, and inst_ok is 4 cycles after data_ok.
- Wait states: addr_ok delayed 3 cycles, data_ok delayed 5 -> bus fields stable throughout, exactly one ok pulse, no second bus_req.
- Flush during fetch DATA phase: inst_flush pulse while waiting for data_ok -> bus transaction completes, no inst_ok, inst_rdata unchanged. A following data_req is served normally.
- Reset mid-transaction: reset=0 during DATA -> all outputs 0 immediately. After release, a new inst_req starts from IDLE with bus_req at +1.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=8: slave never asserts addr_ok -> after 8 cycles in ADDR, RESP is entered, data_ok pulses with data_rdata=0, and bus_err=1 sticky.
